// File: rtl/ej32_pkg.sv
// Shared types and defaults for the EJ32 instruction fetch unit.
package ej32_pkg;
  localparam int ASZ_DEF      = 17;
  localparam int IB_DEPTH_DEF = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_st_t;
endpackage

// File: rtl/ej32_fetch_if.sv
// Memory read port plus decoder-facing instruction byte stream of the fetch unit.
interface ej32_fetch_if
  import ej32_pkg::*;
#(
  parameter int ASZ      = ASZ_DEF,
  parameter int IB_DEPTH = IB_DEPTH_DEF
);
  localparam int LW = $clog2(IB_DEPTH) + 1;

  logic           mem_req;
  logic [ASZ-1:0] mem_addr;
  logic           mem_ack;
  logic [7:0]     mem_data;
  logic           ib_valid;
  logic           ib_ready;
  logic [7:0]     ib_data;
  logic [ASZ-1:0] ib_p;
  logic [LW-1:0]  ib_level;

  modport master (
    output mem_req, mem_addr, ib_valid, ib_data, ib_p, ib_level,
    input  mem_ack, mem_data, ib_ready
  );

  modport slave (
    input  mem_req, mem_addr, ib_valid, ib_data, ib_p, ib_level,
    output mem_ack, mem_data, ib_ready
  );
endinterface

// File: rtl/ej32_ibuf.sv
// Address-tagged instruction byte FIFO with flush; DEPTH must be a power of 2 (>= 2).
module ej32_ibuf
  import ej32_pkg::*;
#(
  parameter int AW    = ASZ_DEF,
  parameter int DEPTH = IB_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     valid,
  output logic [AW-1:0]            head_addr,
  output logic [7:0]               head_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [7:0]    data_q [DEPTH];
  logic [7:0]    data_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok_s, pop_ok_s;

  always_comb begin
    pop_ok_s  = pop && (level_q != '0);
    push_ok_s = push && ((level_q != FULL) || pop_ok_s);
    addr_d    = addr_q;
    data_d    = data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    level_d   = level_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok_s) begin
        addr_d[tail_q] = push_addr;
        data_d[tail_q] = push_data;
        tail_d         = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_ok_s) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  assign valid     = (level_q != '0);
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign level     = level_q;
endmodule

// File: rtl/ej32_fetch.sv
// EJ32 instruction fetch: byte-wide memory requester feeding a small tagged byte buffer.
module ej32_fetch
  import ej32_pkg::*;
#(
  parameter int ASZ      = ASZ_DEF,
  parameter int IB_DEPTH = IB_DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fetch_en,
  input  logic           br_psel,
  input  logic [ASZ-1:0] br_p,
  ej32_fetch_if.master   bus
);
  localparam int LW = $clog2(IB_DEPTH) + 1;
  localparam logic [LW-1:0] FULL   = LW'(IB_DEPTH);
  localparam logic [LW-1:0] ALMOST = LW'(IB_DEPTH - 1);

  fetch_st_t      state_q, state_d;
  logic [ASZ-1:0] fa_q, fa_d;
  logic           accept_s, pop_s, valid_s;
  logic [LW-1:0]  level_s;
  logic [ASZ-1:0] head_addr_s;
  logic [7:0]     head_data_s;

  // A redirect overrides everything: the ack and pop of that cycle are dropped.
  always_comb begin
    accept_s = (state_q == FETCH) && bus.mem_ack && !br_psel;
    pop_s    = valid_s && bus.ib_ready && !br_psel;
    state_d  = state_q;
    fa_d     = fa_q;
    if (br_psel) begin
      fa_d    = br_p;
      state_d = fetch_en ? FETCH : IDLE;
    end else begin
      if (accept_s) begin
        fa_d = fa_q + ASZ'(1);
      end else begin
        fa_d = fa_q;
      end
      case (state_q)
        IDLE: begin
          if (fetch_en && (level_s < FULL)) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH: begin
          if (!fetch_en) begin
            state_d = IDLE;
          end else if (accept_s && !pop_s && (level_s == ALMOST)) begin
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fa_q    <= '0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
    end
  end

  ej32_ibuf #(
    .AW    (ASZ),
    .DEPTH (IB_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .push      (accept_s),
    .push_addr (fa_q),
    .push_data (bus.mem_data),
    .pop       (pop_s),
    .flush     (br_psel),
    .valid     (valid_s),
    .head_addr (head_addr_s),
    .head_data (head_data_s),
    .level     (level_s)
  );

  assign bus.mem_req  = (state_q == FETCH);
  assign bus.mem_addr = fa_q;
  assign bus.ib_valid = valid_s;
  assign bus.ib_data  = head_data_s;
  assign bus.ib_p     = head_addr_s;
  assign bus.ib_level = level_s;
endmodule

// File: tb/tb_ej32_fetch.sv
// Randomised and directed bench for ej32_fetch against an address-stream reference model.
module tb_ej32_fetch;
  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        br_psel;
  logic [16:0] br_p;

  ej32_fetch_if #(.ASZ(17), .IB_DEPTH(4)) bus ();

  ej32_fetch #(.ASZ(17), .IB_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_en (fetch_en),
    .br_psel  (br_psel),
    .br_p     (br_p),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: queue of buffered addresses and next fetch address.
  logic [16:0] q [$];
  logic [16:0] exp_fa;

  logic        o_req, o_valid;
  logic [16:0] o_addr, o_p;
  logic [7:0]  o_data;
  logic [2:0]  o_level;
  int          m_size;
  logic [16:0] m_fa;
  logic        did_pop;
  logic [16:0] pop_exp;

  function automatic logic [7:0] img(input logic [16:0] a);
    logic [7:0] hi;
    hi = a[15:8];
    return a[7:0] + hi * 8'd3 + {7'd0, a[16]};
  endfunction

  task automatic step(input logic fen, input logic ack, input logic rdy,
                      input logic br, input logic [16:0] brp);
    o_req   = bus.mem_req;
    o_addr  = bus.mem_addr;
    o_valid = bus.ib_valid;
    o_p     = bus.ib_p;
    o_data  = bus.ib_data;
    o_level = bus.ib_level;
    m_size  = q.size();
    m_fa    = exp_fa;
    fetch_en     = fen;
    bus.mem_ack  = ack;
    bus.ib_ready = rdy;
    br_psel      = br;
    br_p         = brp;
    bus.mem_data = img(bus.mem_addr);
    did_pop = 1'b0;
    pop_exp = 17'h0;
    if (br) begin
      q.delete();
      exp_fa = brp;
    end else begin
      if (o_valid && rdy) begin
        did_pop = 1'b1;
        if (q.size() != 0) pop_exp = q.pop_front();
      end
      if (o_req && ack) begin
        q.push_back(exp_fa);
        exp_fa = exp_fa + 17'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fetch_en = 1'b0; br_psel = 1'b0; br_p = 17'h0;
    bus.mem_ack = 1'b0; bus.ib_ready = 1'b0; bus.mem_data = 8'h0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_fa = 17'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_en = 1'b0; br_psel = 1'b0; br_p = 17'h0;
    bus.mem_ack = 1'b0; bus.ib_ready = 1'b0; bus.mem_data = 8'h0;
    #1;
    checks += 6;
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.mem_req); end
    if (bus.mem_addr !== 17'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
    if (bus.ib_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.ib_valid); end
    if (bus.ib_data !== 8'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.ib_data); end
    if (bus.ib_p !== 17'h0) begin failures++; $display("FAIL reset_p got=%h exp=0", bus.ib_p); end
    if (bus.ib_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.ib_level); end
  endtask

  task automatic test_stream();
    int first;
    int pops;
    do_reset();
    first = -1;
    pops = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 17'h0);
      checks += 2;
      if (o_req && o_addr !== m_fa) begin failures++; $display("FAIL stream_addr got=%h exp=%h", o_addr, m_fa); end
      if (o_level !== 3'(m_size)) begin failures++; $display("FAIL stream_level got=%0d exp=%0d", o_level, m_size); end
      if (did_pop) begin
        checks++;
        pops++;
        if (first < 0) first = i;
        if (o_p !== pop_exp || o_data !== img(pop_exp))
          begin failures++; $display("FAIL stream_pop got=%h/%h exp=%h/%h", o_p, o_data, pop_exp, img(pop_exp)); end
      end
    end
    checks += 2;
    if (first != 2) begin failures++; $display("FAIL stream_latency got=%0d exp=2", first); end
    if (pops != 28) begin failures++; $display("FAIL stream_rate got=%0d exp=28", pops); end
  endtask

  task automatic test_full();
    int waited;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
    checks += 3;
    if (bus.ib_level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", bus.ib_level); end
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL full_req got=%b exp=0", bus.mem_req); end
    if (bus.ib_p !== 17'h0) begin failures++; $display("FAIL full_head got=%h exp=0", bus.ib_p); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
      checks += 2;
      if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL full_hold_req got=%b exp=0", bus.mem_req); end
      if (bus.ib_level !== 3'd4) begin failures++; $display("FAIL full_hold_level got=%0d exp=4", bus.ib_level); end
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 17'h0);
    checks += 2;
    if (!did_pop || o_p !== 17'h0) begin failures++; $display("FAIL full_pop got=%h exp=0", o_p); end
    if (bus.ib_level !== 3'd3) begin failures++; $display("FAIL full_after_pop got=%0d exp=3", bus.ib_level); end
    waited = 0;
    while (bus.mem_req !== 1'b1 && waited < 4) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 17'h0);
      waited++;
    end
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 17'h4)
      begin failures++; $display("FAIL full_resume got=%b/%h exp=1/00004", bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
    checks++;
    if (bus.ib_level !== 3'd2) begin failures++; $display("FAIL redir_pre_level got=%0d exp=2", bus.ib_level); end
    step(1'b1, 1'b1, 1'b1, 1'b1, 17'h00100);
    checks += 4;
    if (bus.ib_level !== 3'd0) begin failures++; $display("FAIL redir_level got=%0d exp=0", bus.ib_level); end
    if (bus.ib_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", bus.ib_valid); end
    if (bus.mem_addr !== 17'h00100) begin failures++; $display("FAIL redir_addr got=%h exp=00100", bus.mem_addr); end
    if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL redir_req got=%b exp=1", bus.mem_req); end
    step(1'b1, 1'b1, 1'b1, 1'b0, 17'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 17'h0);
    checks++;
    if (!did_pop || o_p !== 17'h00100 || o_data !== img(17'h00100))
      begin failures++; $display("FAIL redir_first got=%h/%h exp=00100/%h", o_p, o_data, img(17'h00100)); end
  endtask

  task automatic test_wrap();
    logic [16:0] got [$];
    logic [16:0] want [3];
    want[0] = 17'h1FFFE; want[1] = 17'h1FFFF; want[2] = 17'h00000;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 17'h1FFFE);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 17'h0);
      if (did_pop) got.push_back(o_p);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got.size() <= i) begin failures++; $display("FAIL wrap_%0d got=none exp=%h", i, want[i]); end
      else if (got[i] !== want[i]) begin failures++; $display("FAIL wrap_%0d got=%h exp=%h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
    checks += 2;
    if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL midrst_pre_req got=%b exp=1", bus.mem_req); end
    if (bus.ib_level !== 3'd3) begin failures++; $display("FAIL midrst_pre_level got=%0d exp=3", bus.ib_level); end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_addr, bus.ib_valid, bus.ib_data, bus.ib_p, bus.ib_level} !== '0)
      begin failures++; $display("FAIL midrst_async got=%b/%h/%b/%h/%h/%0d exp=all zero", bus.mem_req,
        bus.mem_addr, bus.ib_valid, bus.ib_data, bus.ib_p, bus.ib_level); end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_fa = 17'h0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 17'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 17'h0);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 17'h0)
      begin failures++; $display("FAIL midrst_first got=%b/%h exp=1/00000", bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_random();
    int popped;
    logic fen, ack, rdy;
    do_reset();
    popped = 0;
    for (int c = 0; c < 20000 && popped < 1000; c++) begin
      fen = ($urandom_range(0, 99) < 90);
      ack = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < 50);
      step(fen, ack, rdy, 1'b0, 17'h0);
      checks += 3;
      if (o_req && o_addr !== m_fa) begin failures++; $display("FAIL rand_addr got=%h exp=%h", o_addr, m_fa); end
      if (o_level !== 3'(m_size)) begin failures++; $display("FAIL rand_level got=%0d exp=%0d", o_level, m_size); end
      if (o_req && o_level == 3'd4) begin failures++; $display("FAIL rand_req_full got=1 exp=0"); end
      if (did_pop) begin
        checks++;
        popped++;
        if (m_size == 0 || o_p !== pop_exp || o_data !== img(pop_exp))
          begin failures++; $display("FAIL rand_pop got=%h/%h exp=%h/%h", o_p, o_data, pop_exp, img(pop_exp)); end
      end
    end
    checks++;
    if (popped < 1000) begin failures++; $display("FAIL rand_count got=%0d exp=1000", popped); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    q.delete();
    exp_fa = 17'h0;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
